// File: rtl/irq_timer.sv
`default_nettype none
// ============================================================================
//  Module   : irq_timer
//  Purpose  : Memory-mapped down-counting timer that raises a level interrupt
//             when its count expires. It supports one-shot and (optionally)
//             auto-reload operation.
//
//  Register window (16 bytes at ADDR_BASE, decoded on addr[3:2]):
//    0 CTRL   RW  [0] EN, [2:1] MODE (00 one-shot, 01 auto-reload), [3] IM
//    1 PRESET RW  reload value
//    2 COUNT  RO  current count
//    3 --         reads 0, writes ignored
//
//  Ports:
//    clk    - system clock, rising-edge active
//    reset  - asynchronous, active-high reset
//    addr   - CPU byte address
//    we     - write strobe
//    wdata  - write data
//    rdata  - combinational read data for addr
//    irq    - registered interrupt request (pending AND IM)
//
//  Configuration macro:
//    IRQ_TIMER_RELOAD_EN - when defined, MODE=01 selects auto-reload;
//                          when undefined, MODE reads 0 and every count is
//                          one-shot.
//
//  Revision : 1.0 - initial release
// ============================================================================
module irq_timer #(
  parameter logic [31:0] ADDR_BASE = 32'h0000_7F00
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic        we,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        irq
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_CNT  = 2'd2;
  localparam logic [1:0] ST_INT  = 2'd3;

  logic [1:0]  state_q, state_nxt;
  logic [3:0]  ctrl_q, ctrl_nxt, ctrl_eff, ctrl_wr_val;
  logic [31:0] preset_q;
  logic [31:0] count_q, count_nxt;
  logic        pending_q, pending_nxt;

  logic        hit;
  logic [1:0]  offset;
  logic        wr_ctrl, wr_preset;
  logic        en, reload, enter_int;

  // Byte-lane bits carry no meaning for word registers.
  logic        unused_addr_bits;
  assign unused_addr_bits = ^addr[1:0];

  assign hit       = (addr[31:4] == ADDR_BASE[31:4]);
  assign offset    = addr[3:2];
  assign wr_ctrl   = we && hit && (offset == 2'd0);
  assign wr_preset = we && hit && (offset == 2'd1);

`ifdef IRQ_TIMER_RELOAD_EN
  assign ctrl_wr_val = wdata[3:0];
`else
  // Without auto-reload support the MODE field is stored as zero and reads back as zero.
  assign ctrl_wr_val = {wdata[3], 2'b00, wdata[0]};
`endif

  // The FSM acts on the CTRL value being written at this edge, so a write
  // that sets or clears EN takes effect without an extra cycle of delay.
  assign ctrl_eff = wr_ctrl ? ctrl_wr_val : ctrl_q;
  assign en       = ctrl_eff[0];

`ifdef IRQ_TIMER_RELOAD_EN
  assign reload = (ctrl_eff[2:1] == 2'b01);
`else
  assign reload = 1'b0;
`endif

  always_comb begin
    state_nxt   = state_q;
    count_nxt   = count_q;
    ctrl_nxt    = ctrl_eff;
    enter_int   = 1'b0;
    pending_nxt = pending_q;

    case (state_q)
      ST_IDLE: begin
        if (en) state_nxt = ST_LOAD;
      end
      ST_LOAD: begin
        count_nxt = preset_q;
        state_nxt = ST_CNT;
      end
      ST_CNT: begin
        if (!en) begin
          state_nxt = ST_IDLE;
        end else if (count_q > 32'd1) begin
          count_nxt = count_q - 32'd1;
        end else begin
          // Covers both COUNT==1 and a zero PRESET; never wraps below zero.
          count_nxt = 32'd0;
          state_nxt = ST_INT;
          enter_int = 1'b1;
        end
      end
      default: begin // ST_INT
        if (reload) begin
          state_nxt = ST_LOAD;
        end else begin
          state_nxt = ST_IDLE;
          // A simultaneous software CTRL write wins over the automatic clear.
          if (!wr_ctrl) ctrl_nxt[0] = 1'b0;
        end
      end
    endcase

    if (wr_ctrl || wr_preset) pending_nxt = 1'b0;
    if ((state_q == ST_INT) && reload) pending_nxt = 1'b0;
    if (enter_int) pending_nxt = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      ctrl_q    <= 4'd0;
      preset_q  <= 32'd0;
      count_q   <= 32'd0;
      pending_q <= 1'b0;
      irq       <= 1'b0;
    end else begin
      state_q   <= state_nxt;
      ctrl_q    <= ctrl_nxt;
      count_q   <= count_nxt;
      pending_q <= pending_nxt;
      irq       <= pending_nxt & ctrl_nxt[3];
      if (wr_preset) preset_q <= wdata;
    end
  end

  always_comb begin
    rdata = 32'd0;
    if (hit) begin
      case (offset)
        2'd0:    rdata = {28'd0, ctrl_q};
        2'd1:    rdata = preset_q;
        2'd2:    rdata = count_q;
        default: rdata = 32'd0;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_irq_timer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_irq_timer
//  Purpose  : Self-checking bench for irq_timer. Expected COUNT/irq values
//             are computed from closed-form timing of the timer (cycles since
//             the enabling CTRL write), not from a state machine.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_irq_timer;

  localparam logic [31:0] BASE     = 32'h0000_7F00;
  localparam logic [31:0] A_CTRL   = BASE;
  localparam logic [31:0] A_PRESET = BASE + 32'd4;
  localparam logic [31:0] A_COUNT  = BASE + 32'd8;
  localparam logic [31:0] A_UNMAP  = BASE + 32'd12;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] addr;
  logic        we;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        irq;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  irq_timer #(.ADDR_BASE(BASE)) dut (
    .clk   (clk),
    .reset (reset),
    .addr  (addr),
    .we    (we),
    .wdata (wdata),
    .rdata (rdata),
    .irq   (irq)
  );

  initial begin
    #300000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  // One bus cycle: inputs change on the falling edge, the active edge
  // follows, and the bench resumes 1 time unit after it.
  task automatic cycle(input logic w, input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    addr = a; we = w; wdata = d;
    @(posedge clk);
    #1;
    we = 1'b0; wdata = 32'd0; addr = A_COUNT;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] v);
    addr = a;
    #1;
    v = rdata;
  endtask

  // Reference timing, k = edges since the enabling CTRL write.
  // Expiry happens at edge max(N,1)+1; in reload mode it recurs every
  // max(N,1)+2 edges (one LOAD edge, then N..0).
  function automatic void model(input int n, input int k, input bit im, input bit rl,
                                output logic [31:0] c, output logic q);
    int ti;
    int p;
    int j;
    ti = ((n < 1) ? 1 : n) + 1;
    p  = ((n < 1) ? 1 : n) + 2;
    if (k <= ti) begin
      c = (n - (k - 1) > 0) ? 32'(n - (k - 1)) : 32'd0;
      q = im && (k == ti);
    end else if (!rl) begin
      c = 32'd0;
      q = im;
    end else begin
      j = (k - ti) % p;
      c = (j >= 2 && (n - (j - 2)) > 0) ? 32'(n - (j - 2)) : 32'd0;
      q = im && (j == 0);
    end
  endfunction

  task automatic test_reset;
    logic [31:0] v;
    reset = 1'b1; we = 1'b0; addr = A_COUNT; wdata = 32'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    rd(A_CTRL, v);
    checks++; if (v !== 32'd0) begin errors++; $display("FAIL reset_ctrl got %h want %h", v, 32'd0); end
    rd(A_PRESET, v);
    checks++; if (v !== 32'd0) begin errors++; $display("FAIL reset_preset got %h want %h", v, 32'd0); end
    rd(A_COUNT, v);
    checks++; if (v !== 32'd0) begin errors++; $display("FAIL reset_count got %h want %h", v, 32'd0); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq got %b want 0", irq); end
  endtask

  task automatic test_oneshot;
    logic [31:0] v, ec;
    logic eq;
    cycle(1'b1, A_PRESET, 32'd5);
    cycle(1'b1, A_CTRL, 32'h9);
    for (int k = 1; k <= 9; k++) begin
      cycle(1'b0, A_COUNT, 32'd0);
      model(5, k, 1'b1, 1'b0, ec, eq);
      rd(A_COUNT, v);
      checks++; if (v !== ec) begin errors++; $display("FAIL oneshot_count k=%0d got %0d want %0d", k, v, ec); end
      checks++; if (irq !== eq) begin errors++; $display("FAIL oneshot_irq k=%0d got %b want %b", k, irq, eq); end
      rd(A_CTRL, v);
      checks++; if (v !== ((k >= 7) ? 32'h8 : 32'h9)) begin
        errors++; $display("FAIL oneshot_ctrl k=%0d got %h want %h", k, v, (k >= 7) ? 32'h8 : 32'h9);
      end
    end
    cycle(1'b1, A_CTRL, 32'h0);
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL oneshot_irq_clear got %b want 0", irq); end
  endtask

  task automatic test_masked;
    logic [31:0] v, ec;
    logic eq;
    cycle(1'b1, A_PRESET, 32'd2);
    cycle(1'b1, A_CTRL, 32'h1);
    for (int k = 1; k <= 6; k++) begin
      cycle(1'b0, A_COUNT, 32'd0);
      model(2, k, 1'b0, 1'b0, ec, eq);
      rd(A_COUNT, v);
      checks++; if (v !== ec) begin errors++; $display("FAIL masked_count k=%0d got %0d want %0d", k, v, ec); end
      checks++; if (irq !== 1'b0) begin errors++; $display("FAIL masked_irq k=%0d got %b want 0", k, irq); end
    end
    rd(A_CTRL, v);
    checks++; if (v !== 32'h0) begin errors++; $display("FAIL masked_en_clear got %h want 0", v); end
  endtask

  task automatic test_preset_zero;
    logic [31:0] v, ec;
    logic eq;
    cycle(1'b1, A_PRESET, 32'd0);
    cycle(1'b1, A_CTRL, 32'h9);
    for (int k = 1; k <= 5; k++) begin
      cycle(1'b0, A_COUNT, 32'd0);
      model(0, k, 1'b1, 1'b0, ec, eq);
      rd(A_COUNT, v);
      checks++; if (v !== ec) begin errors++; $display("FAIL zero_count k=%0d got %h want %h", k, v, ec); end
      checks++; if (irq !== eq) begin errors++; $display("FAIL zero_irq k=%0d got %b want %b", k, irq, eq); end
    end
    cycle(1'b1, A_CTRL, 32'h0);
  endtask

  task automatic test_disable_and_decode;
    logic [31:0] v;
    cycle(1'b1, A_PRESET, 32'd10);
    cycle(1'b1, A_CTRL, 32'h9);
    for (int k = 1; k <= 7; k++) cycle(1'b0, A_COUNT, 32'd0);
    rd(A_COUNT, v);
    checks++; if (v !== 32'd4) begin errors++; $display("FAIL dis_pre_count got %0d want 4", v); end
    cycle(1'b1, A_CTRL, 32'h0);
    for (int i = 0; i < 4; i++) begin
      rd(A_COUNT, v);
      checks++; if (v !== 32'd4) begin errors++; $display("FAIL dis_frozen i=%0d got %0d want 4", i, v); end
      checks++; if (irq !== 1'b0) begin errors++; $display("FAIL dis_irq i=%0d got %b want 0", i, irq); end
      cycle(1'b0, A_COUNT, 32'd0);
    end
    rd(A_UNMAP, v);
    checks++; if (v !== 32'd0) begin errors++; $display("FAIL unmapped_read got %h want 0", v); end
    rd(BASE + 32'h10, v);
    checks++; if (v !== 32'd0) begin errors++; $display("FAIL miss_read_hi got %h want 0", v); end
    rd(BASE - 32'd8, v);
    checks++; if (v !== 32'd0) begin errors++; $display("FAIL miss_read_lo got %h want 0", v); end
    cycle(1'b1, A_COUNT, 32'd123);
    rd(A_COUNT, v);
    checks++; if (v !== 32'd4) begin errors++; $display("FAIL count_ro got %0d want 4", v); end
    cycle(1'b1, BASE + 32'h10, 32'hF);
    cycle(1'b1, A_UNMAP, 32'hF);
    rd(A_CTRL, v);
    checks++; if (v !== 32'd0) begin errors++; $display("FAIL miss_write got %h want 0", v); end
    cycle(1'b1, A_CTRL, 32'hFFFF_FFF6);
    rd(A_CTRL, v);
`ifdef IRQ_TIMER_RELOAD_EN
    checks++; if (v !== 32'h6) begin errors++; $display("FAIL ctrl_upper got %h want %h", v, 32'h6); end
`else
    checks++; if (v !== 32'h0) begin errors++; $display("FAIL ctrl_upper got %h want %h", v, 32'h0); end
`endif
    cycle(1'b1, A_CTRL, 32'h0);
  endtask

  task automatic test_preset_during_cnt;
    logic [31:0] v, ec;
    logic eq;
    cycle(1'b1, A_PRESET, 32'd6);
    cycle(1'b1, A_CTRL, 32'h9);
    for (int k = 1; k <= 9; k++) begin
      if (k == 3) cycle(1'b1, A_PRESET, 32'd50);
      else        cycle(1'b0, A_COUNT, 32'd0);
      model(6, k, 1'b1, 1'b0, ec, eq);
      rd(A_COUNT, v);
      checks++; if (v !== ec) begin errors++; $display("FAIL pcnt_count k=%0d got %0d want %0d", k, v, ec); end
      checks++; if (irq !== eq) begin errors++; $display("FAIL pcnt_irq k=%0d got %b want %b", k, irq, eq); end
    end
    rd(A_PRESET, v);
    checks++; if (v !== 32'd50) begin errors++; $display("FAIL pcnt_preset got %0d want 50", v); end
    cycle(1'b1, A_CTRL, 32'h0);
  endtask

  task automatic test_reload;
    logic [31:0] v, ec;
    logic eq;
    bit rl;
`ifdef IRQ_TIMER_RELOAD_EN
    rl = 1'b1;
`else
    rl = 1'b0;
`endif
    cycle(1'b1, A_PRESET, 32'd3);
    cycle(1'b1, A_CTRL, 32'hB);
    rd(A_CTRL, v);
    checks++; if (v !== (rl ? 32'hB : 32'h9)) begin
      errors++; $display("FAIL reload_ctrl got %h want %h", v, rl ? 32'hB : 32'h9);
    end
    for (int k = 1; k <= 20; k++) begin
      cycle(1'b0, A_COUNT, 32'd0);
      model(3, k, 1'b1, rl, ec, eq);
      rd(A_COUNT, v);
      checks++; if (v !== ec) begin errors++; $display("FAIL reload_count k=%0d got %0d want %0d", k, v, ec); end
      checks++; if (irq !== eq) begin errors++; $display("FAIL reload_irq k=%0d got %b want %b", k, irq, eq); end
    end
    cycle(1'b1, A_CTRL, 32'h0);
    repeat (3) cycle(1'b0, A_COUNT, 32'd0);
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL reload_stop_irq got %b want 0", irq); end
  endtask

  task automatic test_reset_midcount;
    logic [31:0] v;
    cycle(1'b1, A_PRESET, 32'd10);
    cycle(1'b1, A_CTRL, 32'h9);
    for (int k = 1; k <= 4; k++) cycle(1'b0, A_COUNT, 32'd0);
    rd(A_COUNT, v);
    checks++; if (v !== 32'd7) begin errors++; $display("FAIL rst_pre_count got %0d want 7", v); end
    #2;
    reset = 1'b1;
    #1;
    rd(A_CTRL, v);
    checks++; if (v !== 32'd0) begin errors++; $display("FAIL rst_mid_ctrl got %h want 0", v); end
    rd(A_PRESET, v);
    checks++; if (v !== 32'd0) begin errors++; $display("FAIL rst_mid_preset got %h want 0", v); end
    rd(A_COUNT, v);
    checks++; if (v !== 32'd0) begin errors++; $display("FAIL rst_mid_count got %h want 0", v); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL rst_mid_irq got %b want 0", irq); end
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 12; i++) begin
      cycle(1'b0, A_COUNT, 32'd0);
      rd(A_COUNT, v);
      checks++; if (v !== 32'd0 || irq !== 1'b0) begin
        errors++; $display("FAIL rst_idle i=%0d got count %0d irq %b want 0 0", i, v, irq);
      end
    end
  endtask

  task automatic test_random;
    logic [31:0] v, ec, ectrl;
    logic eq;
    int n, ti, p, kd, kend;
    bit im, rl;
    logic [1:0] mode, mode_st;
    for (int it = 0; it < 10; it++) begin
      n    = int'($urandom_range(0, 12));
      im   = 1'($urandom_range(0, 1));
      mode = 2'($urandom_range(0, 3));
`ifdef IRQ_TIMER_RELOAD_EN
      rl = (mode == 2'b01);
      mode_st = mode;
`else
      rl = 1'b0;
      mode_st = 2'b00;
`endif
      ti   = ((n < 1) ? 1 : n) + 1;
      p    = ((n < 1) ? 1 : n) + 2;
      kd   = (n >= 2 && $urandom_range(0, 1) == 1) ? int'($urandom_range(2, ti - 1)) : 0;
      kend = ti + 2 * p + 2;
      ectrl = {28'd0, im, mode_st, 1'b1};
      cycle(1'b1, A_PRESET, 32'(n));
      cycle(1'b1, A_CTRL, {28'd0, im, mode, 1'b1});
      for (int k = 1; k <= kend; k++) begin
        if (k == kd) cycle(1'b1, A_CTRL, 32'h0);
        else         cycle(1'b0, A_COUNT, 32'd0);
        if (kd != 0 && k >= kd) begin
          ec = 32'(n - (kd - 2));
          eq = 1'b0;
        end else begin
          model(n, k, im, rl, ec, eq);
        end
        if (k == 1) begin
          rd(A_CTRL, v);
          checks++; if (v !== ectrl) begin errors++; $display("FAIL rand_ctrl it=%0d got %h want %h", it, v, ectrl); end
        end
        rd(A_COUNT, v);
        checks++; if (v !== ec) begin
          errors++; $display("FAIL rand_count it=%0d n=%0d k=%0d got %0d want %0d", it, n, k, v, ec);
        end
        checks++; if (irq !== eq) begin
          errors++; $display("FAIL rand_irq it=%0d n=%0d k=%0d got %b want %b", it, n, k, irq, eq);
        end
      end
      cycle(1'b1, A_CTRL, 32'h0);
      repeat (3) cycle(1'b0, A_COUNT, 32'd0);
      checks++; if (irq !== 1'b0) begin errors++; $display("FAIL rand_stop_irq it=%0d got %b want 0", it, irq); end
    end
  endtask

  initial begin
    test_reset;
    test_oneshot;
    test_masked;
    test_preset_zero;
    test_disable_and_decode;
    test_preset_during_cnt;
    test_reload;
    test_reset_midcount;
    test_random;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
